usb_rx_rcu: RTL

- Receive control unit for the USB 1.1 full-speed RX path, directly downstream of the bit timer.
- Consumes the timer's per-bit shift_enable and per-byte byte_received strobes, the shift register's parallel byte, and the EOP detector.
- Owns the rcving qualifier that gates the timer.
- Validates SYNC and PID, writes payload bytes to the RX FIFO, and reports packet type, completion and error to the protocol layer.

---
 rtl/usb_rx_rcu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/usb_rx_rcu.sv
// USB 1.1 full-speed receive control unit.
// Sits behind the bit timer. It checks SYNC and PID, forwards DATA payload
// bytes to the RX FIFO, and reports packet type, completion and error.
// Every output is a register, so each response appears one clock after its cause.
module usb_rx_rcu #(
    parameter int MAX_DATA_BYTES = 66,
    parameter int CNT_BITS       = 7
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       flush,
    output logic [2:0] rx_packet,
    output logic       rx_done,
    output logic       r_error
);

    typedef enum logic [2:0] {
        IDLE, SYNC_WAIT, PID_WAIT, BODY, EOP_CHK, DONE, ERR_WAIT
    } state_t;

    localparam logic [CNT_BITS-1:0] MAX_C = CNT_BITS'(MAX_DATA_BYTES);
    localparam logic [CNT_BITS-1:0] SAT_C = CNT_BITS'(MAX_DATA_BYTES + 1);

    state_t              state_q;
    logic                rcving_q;
    logic                w_enable_q;
    logic                flush_q;
    logic [2:0]          rx_packet_q;
    logic                rx_done_q;
    logic                r_error_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic                eop_bit;
    logic                is_data;
    logic                is_token;
    logic                is_hshake;
    logic                count_ok;
    logic [2:0]          pid_code;

    // Map a PID byte to its packet code. Return 0 if the check nibble is wrong
    // or the PID is not one this unit handles.
    function automatic logic [2:0] pid_decode(input logic [7:0] b);
        logic [2:0] code;
        code = 3'd0;
        if (b[7:4] == ~b[3:0]) begin
            case (b[3:0])
                4'b0001: code = 3'd1;
                4'b1001: code = 3'd2;
                4'b0011: code = 3'd3;
                4'b1011: code = 3'd4;
                4'b0010: code = 3'd5;
                4'b1010: code = 3'd6;
                4'b1110: code = 3'd7;
                default: code = 3'd0;
            endcase
        end
        return code;
    endfunction

    // EOP counts only when sampled at a bit centre; this also filters glitches.
    // The next byte count stops at MAX+1 and never wraps.
    always_comb begin
        eop_bit   = eop & shift_enable;
        cnt_d     = (cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;
        pid_code  = pid_decode(rcv_data);
        is_token  = (rx_packet_q == 3'd1) || (rx_packet_q == 3'd2);
        is_data   = (rx_packet_q == 3'd3) || (rx_packet_q == 3'd4);
        is_hshake = (rx_packet_q >= 3'd5);
        count_ok  = 1'b0;
        if (is_hshake)
            count_ok = (cnt_q == '0);
        else if (is_token)
            count_ok = (cnt_q == CNT_BITS'(2));
        else if (is_data)
            count_ok = (cnt_q >= CNT_BITS'(2)) && (cnt_q <= MAX_C);
    end

    // Packet control FSM. It drives all outputs as registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            rcving_q    <= 1'b0;
            w_enable_q  <= 1'b0;
            flush_q     <= 1'b0;
            rx_packet_q <= 3'd0;
            rx_done_q   <= 1'b0;
            r_error_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            flush_q    <= 1'b0;
            w_enable_q <= 1'b0;
            rx_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_edge) begin
                        state_q     <= SYNC_WAIT;
                        rcving_q    <= 1'b1;
                        flush_q     <= 1'b1;
                        r_error_q   <= 1'b0;
                        rx_packet_q <= 3'd0;
                    end
                end
                SYNC_WAIT: begin
                    if (byte_received && rcv_data == 8'h80 && !eop_bit) begin
                        state_q <= PID_WAIT;
                    end else if (byte_received || eop_bit) begin
                        state_q   <= ERR_WAIT;
                        r_error_q <= 1'b1;
                    end
                end
                PID_WAIT: begin
                    if (byte_received && pid_code != 3'd0) begin
                        rx_packet_q <= pid_code;
                        cnt_q       <= '0;
                        state_q     <= eop_bit ? EOP_CHK : BODY;
                    end else if (byte_received || eop_bit) begin
                        state_q   <= ERR_WAIT;
                        r_error_q <= 1'b1;
                    end
                end
                BODY: begin
                    if (byte_received) begin
                        cnt_q <= cnt_d;
                        if (is_hshake || cnt_d > MAX_C) begin
                            state_q   <= ERR_WAIT;
                            r_error_q <= 1'b1;
                        end else begin
                            w_enable_q <= is_data;
                            if (eop_bit)
                                state_q <= EOP_CHK;
                        end
                    end else if (eop_bit) begin
                        state_q <= EOP_CHK;
                    end
                end
                EOP_CHK: begin
                    if (count_ok) begin
                        state_q   <= DONE;
                        rx_done_q <= 1'b1;
                        rcving_q  <= 1'b0;
                    end else begin
                        state_q   <= ERR_WAIT;
                        r_error_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERR_WAIT: begin
                    if (eop_bit) begin
                        rcving_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rcving    = rcving_q;
    assign w_enable  = w_enable_q;
    assign flush     = flush_q;
    assign rx_packet = rx_packet_q;
    assign rx_done   = rx_done_q;
    assign r_error   = r_error_q;

endmodule
